rv32i_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the RV32I core's decoder.
- Generates sequential word addresses from a fetch PC and issues them to an instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small prefetch FIFO and presents one instruction at a time, tagged with its PC, to the decoder over a valid/ready channel.
- Handles branch/jump redirects by flushing the FIFO and discarding stale in-flight responses.

---
 rtl/rv32i_fetch_unit.sv | 158 +++++++++++++++
 tb/tb_rv32i_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch stage: sequential word fetch with credit-limited prefetch FIFO,
// in-order response tagging, and redirect handling that flushes and drops stale responses.
module rv32i_fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] instr_pc
);

  localparam int unsigned     PW         = $clog2(FIFO_DEPTH);
  localparam int unsigned     CW         = PW + 1;
  localparam int unsigned     SW         = CW + 1;
  localparam logic [SW-1:0]   DEPTH_L    = SW'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(3'd4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(2'b11));

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_r, state_next_s;
  logic [XLEN-1:0] fetch_pc_r, fetch_pc_next_s;
  logic            req_valid_r, req_valid_next_s;
  logic            instr_valid_r, instr_valid_next_s;
  logic [CW-1:0]   out_r, out_next_s;
  logic [CW-1:0]   drop_r, drop_next_s;
  logic [CW-1:0]   count_r, count_next_s;
  logic [SW-1:0]   credit_sum_s;
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [PW-1:0]   tag_wr_ptr_r, tag_rd_ptr_r;
  logic [XLEN-1:0] data_mem_r [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem_r   [FIFO_DEPTH];
  logic [XLEN-1:0] tag_mem_r  [FIFO_DEPTH];
  logic            acc_s, pop_s, push_s;

  assign imem_req_valid = req_valid_r;
  assign imem_req_addr  = fetch_pc_r;
  assign instr_valid    = instr_valid_r;
  assign instruction    = data_mem_r[rd_ptr_r];
  assign instr_pc       = pc_mem_r[rd_ptr_r];

  // Next-state computation for FSM, credits, drop counter, fetch PC and registered valids
  always_comb begin
    acc_s        = req_valid_r & imem_req_ready;
    pop_s        = instr_valid_r & instr_ready;
    push_s       = imem_rsp_valid & (drop_r == '0) & ~redirect_valid;
    out_next_s   = out_r + CW'(acc_s) - CW'(imem_rsp_valid);
    state_next_s = state_r;
    drop_next_s  = drop_r;
    count_next_s = count_r;
    fetch_pc_next_s = fetch_pc_r;
    if (redirect_valid) begin
      // Every request still in flight after this cycle belongs to the old stream.
      count_next_s    = '0;
      drop_next_s     = out_next_s;
      fetch_pc_next_s = redirect_pc & ALIGN_MASK;
      if (out_next_s != '0) begin
        state_next_s = DRAIN;
      end else begin
        state_next_s = RUN;
      end
    end else begin
      count_next_s = count_r + CW'(push_s) - CW'(pop_s);
      if (imem_rsp_valid && (drop_r != '0)) begin
        drop_next_s = drop_r - CW'(1'b1);
      end else begin
        drop_next_s = drop_r;
      end
      if (acc_s) begin
        fetch_pc_next_s = fetch_pc_r + PC_STEP;
      end else begin
        fetch_pc_next_s = fetch_pc_r;
      end
      case (state_r)
        BOOT:    state_next_s = RUN;
        RUN:     state_next_s = RUN;
        DRAIN: begin
          if (drop_next_s == '0) begin
            state_next_s = RUN;
          end else begin
            state_next_s = DRAIN;
          end
        end
        default: state_next_s = BOOT;
      endcase
    end
    credit_sum_s       = SW'(count_next_s) + SW'(out_next_s);
    req_valid_next_s   = (state_next_s == RUN) && !redirect_valid && (credit_sum_s < DEPTH_L);
    instr_valid_next_s = (count_next_s != '0);
  end

  // State, prefetch FIFO and outstanding-request tag storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= BOOT;
      fetch_pc_r    <= RESET_PC;
      req_valid_r   <= 1'b0;
      instr_valid_r <= 1'b0;
      out_r         <= '0;
      drop_r        <= '0;
      count_r       <= '0;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      tag_wr_ptr_r  <= '0;
      tag_rd_ptr_r  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_r[i] <= '0;
        pc_mem_r[i]   <= '0;
        tag_mem_r[i]  <= '0;
      end
    end else begin
      state_r       <= state_next_s;
      fetch_pc_r    <= fetch_pc_next_s;
      req_valid_r   <= req_valid_next_s;
      instr_valid_r <= instr_valid_next_s;
      out_r         <= out_next_s;
      drop_r        <= drop_next_s;
      count_r       <= count_next_s;
      if (redirect_valid) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (push_s) begin
          data_mem_r[wr_ptr_r] <= imem_rsp_data;
          pc_mem_r[wr_ptr_r]   <= tag_mem_r[tag_rd_ptr_r];
          wr_ptr_r             <= wr_ptr_r + PW'(1'b1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PW'(1'b1);
        end
      end
      // Tags retire on every response, dropped or not, so they stay aligned with memory order.
      if (acc_s) begin
        tag_mem_r[tag_wr_ptr_r] <= fetch_pc_r;
        tag_wr_ptr_r            <= tag_wr_ptr_r + PW'(1'b1);
      end
      if (imem_rsp_valid) begin
        tag_rd_ptr_r <= tag_rd_ptr_r + PW'(1'b1);
      end
    end
  end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Scoreboard bench for rv32i_fetch_unit: directed scenarios push expected PCs, a monitor
// compares every decoder handshake; an in-order memory model with variable latency responds.
module tb_rv32i_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc = 0;
  int          mem_lat = 1;
  int          acc_cnt = 0;
  int          rsp_cnt = 0;
  int          acc_base;
  int          rsp_base;

  rv32i_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_range(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_req_valid(input string name);
    int k;
    for (k = 0; k < 20; k++) begin
      if (imem_req_valid) break;
      @(posedge clk); #1;
    end
    check(name, 32'(imem_req_valid), 32'd1);
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    instr_ready = 1'b0;
  endtask

  // In-order instruction memory: responses appear mem_lat cycles after acceptance
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        mq_addr.delete();
        mq_due.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end else begin
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(mq_addr[0]);
          void'(mq_addr.pop_front());
          void'(mq_due.pop_front());
          rsp_cnt++;
        end else begin
          imem_rsp_valid = 1'b0;
        end
        if (imem_req_valid && imem_req_ready) begin
          mq_addr.push_back(imem_req_addr);
          mq_due.push_back(cyc + mem_lat);
          acc_cnt++;
        end
      end
    end
  end

  // Decoder-side monitor: every consumed instruction must match the scoreboard head
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr actual_pc=%h required=none", instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e);
          check("instruction", instruction, mem_word(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0000_0000);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instruction", instruction, 32'h0000_0000);
    check("rst_instr_pc", instr_pc, 32'h0000_0000);

    // Streaming: BOOT cycle, latency 3 to first instruction, then one per cycle
    imem_req_ready = 1'b1; instr_ready = 1'b1; mem_lat = 1;
    push_range(32'h0, 16);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t1_first_req_valid", 32'(imem_req_valid), 32'd1);
    check("t1_first_req_addr", imem_req_addr, 32'h0000_0000);
    @(posedge clk); #1;
    check("t1_no_instr_yet", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_first_instr_valid", 32'(instr_valid), 32'd1);
    check("t1_first_instruction", instruction, 32'h0000_0013);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("t1_throughput", 32'(instr_valid), 32'd1);
    end
    drain("t1_drain", 60);

    // Decoder stalled: four buffered, credits exhausted
    imem_req_ready = 1'b1; instr_ready = 1'b0; mem_lat = 1;
    do_reset();
    acc_base = acc_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("t2_accepts", 32'(acc_cnt - acc_base), 32'd4);
    check("t2_req_valid_off", 32'(imem_req_valid), 32'd0);
    check("t2_instr_valid", 32'(instr_valid), 32'd1);
    check("t2_head_pc", instr_pc, 32'h0000_0000);
    push_range(32'h0, 8);
    instr_ready = 1'b1;
    drain("t2_drain", 60);

    // Redirect with two responses in flight at latency 3
    imem_req_ready = 1'b0; instr_ready = 1'b0; mem_lat = 3;
    do_reset();
    wait_req_valid("t3_wait_valid");
    acc_base = acc_cnt;
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    check("t3_outstanding", 32'(acc_cnt - acc_base), 32'd2);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    @(posedge clk); #1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    check("t3_drain1_req_valid", 32'(imem_req_valid), 32'd0);
    check("t3_drain1_instr_valid", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    check("t3_drain2_req_valid", 32'(imem_req_valid), 32'd0);
    check("t3_drain2_instr_valid", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    check("t3_resume_req_valid", 32'(imem_req_valid), 32'd1);
    check("t3_resume_addr", imem_req_addr, 32'h0000_0100);
    push_range(32'h100, 8);
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    drain("t3_drain", 100);

    // Misaligned redirect target with nothing outstanding
    imem_req_ready = 1'b0; instr_ready = 1'b0; mem_lat = 1;
    do_reset();
    wait_req_valid("t4_wait_valid");
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    @(posedge clk); #1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    check("t4_req_valid_drop", 32'(imem_req_valid), 32'd0);
    @(posedge clk); #1;
    check("t4_req_valid", 32'(imem_req_valid), 32'd1);
    check("t4_req_addr", imem_req_addr, 32'h0000_0200);
    push_range(32'h200, 8);
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    drain("t4_drain", 60);

    // Back-pressured request stays stable until a redirect abandons it
    imem_req_ready = 1'b0; instr_ready = 1'b0; mem_lat = 1;
    do_reset();
    wait_req_valid("t5_wait_valid");
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_hold_valid", 32'(imem_req_valid), 32'd1);
      check("t5_hold_addr", imem_req_addr, 32'h0000_0008);
      if (i == 2) begin
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
      end
      @(posedge clk); #1;
    end
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    check("t5_req_valid_drop", 32'(imem_req_valid), 32'd0);
    @(posedge clk); #1;
    check("t5_req_valid", 32'(imem_req_valid), 32'd1);
    check("t5_req_addr", imem_req_addr, 32'h0000_0300);
    push_range(32'h300, 8);
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    drain("t5_drain", 60);

    // Reset with responses outstanding and FIFO occupied
    imem_req_ready = 1'b0; instr_ready = 1'b0; mem_lat = 3;
    do_reset();
    wait_req_valid("t6_wait_valid");
    rsp_base = rsp_cnt;
    imem_req_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (rsp_cnt - rsp_base >= 2) break;
    end
    check("t6_fifo_filled", 32'(instr_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("t6_rst_req_addr", imem_req_addr, 32'h0000_0000);
    check("t6_rst_instr_valid", 32'(instr_valid), 32'd0);
    check("t6_rst_instruction", instruction, 32'h0000_0000);
    check("t6_rst_instr_pc", instr_pc, 32'h0000_0000);
    mem_lat = 1; instr_ready = 1'b1;
    push_range(32'h0, 8);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    drain("t6_drain", 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
